pico_fifo_wr_arbiter: RTL and testbench
=======================================

# pico_fifo_wr_arbiter

Round-robin write arbiter that shares one 512x128 input FIFO (`fifo_512x128_in`) between up to NUM_REQ stream producers on the write-clock side. Each producer offers bursts of 128-bit beats. The arbiter grants one producer at a time and forwards its accepted beats, registered, to the FIFO write port. Grants are gated by the FIFO's prog_full so that a granted burst always completes without overflow. It sits between the user-logic stream sources and the FIFO's `clk`-domain write interface.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BURST_MAX, 16, maximum beats per grant; must be ≤ the FIFO ALMOST_FULL_OFFSET
- IDW, $clog2(NUM_REQ), grant index width (derived, not overridden)

Ports:
- clk  in  1  write-side clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester beat valid
- req_data  in  NUM_REQ*128  per-requester beat; requester i occupies [128*i+127:128*i]
- req_last  in  NUM_REQ  per-requester end-of-burst marker, qualified by valid
- req_ready  out  NUM_REQ  per-requester beat accept
- fifo_din  out  128  to FIFO din
- fifo_dinp  out  16  to FIFO dinp
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_full  in  1  from FIFO full
- fifo_prog_full  in  1  from FIFO prog_full
- grant_id  out  IDW  index of the current or last granted requester
- busy  out  1  high while in BURST

## Operation
- FSM states: IDLE, BURST.
- IDLE → BURST:
  - Condition: |req_valid and !fifo_prog_full.
  - Winner: first valid requester at or after rr_ptr, searching in increasing index order with wrap.
  - Registers: grant_id ← winner, beat_cnt ← 0.
- In BURST:
  - req_ready[grant_id] = !fifo_full. All other req_ready bits are 0. All req_ready bits are 0 in IDLE.
  - A beat is accepted when req_valid[g] & req_ready[g]. On acceptance: beat_cnt increments, fifo_din ← req_data slice, fifo_wr_en ← 1.
  - When no beat is accepted, fifo_wr_en ← 0 and fifo_din holds its value.
- BURST → IDLE when the accepted beat has req_last, or when beat_cnt reaches BURST_MAX-1. Registers: rr_ptr ← (grant_id+1) mod NUM_REQ.
- A requester deasserting valid mid-burst keeps the grant. There is no timeout.
- fifo_prog_full rising mid-burst has no effect. BURST_MAX ≤ ALMOST_FULL_OFFSET guarantees space.
- beat_cnt is $clog2(BURST_MAX+1) bits and never wraps.

## Timing
- Reset values: req_ready=0, fifo_wr_en=0, fifo_din=0, fifo_dinp=0, grant_id=0, busy=0, rr_ptr=0, state IDLE.
- Grant latency: valid seen in IDLE at cycle N → grant at edge N+1 → earliest beat accept in cycle N+1.
- Data latency: an accepted beat appears on fifo_din/fifo_wr_en at the following edge (1 cycle).
- Burst end: one IDLE bubble cycle always precedes the next grant, including a re-grant to the same requester.
- fifo_full is combinational into req_ready. The FIFO wrapper registers full, so the bubble plus the prog_full gating covers that lag.
- Reset asserted mid-burst: all outputs return to reset values immediately. The partial burst is abandoned; any beat registered but not yet written is dropped.

## Configuration
- PICO_ARB_PARITY_EN defined:
  - fifo_dinp[k] ← ^fifo_din[8k+7:8k] (even byte parity), registered with the data.
- PICO_ARB_PARITY_EN undefined:
  - fifo_dinp is tied to 16'h0000.
  - No parity logic is generated.

## Structure
- Shared package pico_arb_pkg holds:
  - state enum {IDLE, BURST}
  - localparam DATA_W=128, PAR_W=16
  - function for the round-robin search
- One sub-module, pico_rr_pick: combinational round-robin priority picker with inputs (req, ptr) and outputs (gnt_idx, any). The FSM, counter and output registers stay in the top.

## Test plan
- Single requester 0 sends a 4-beat burst (last on beat 4), FIFO empty → grant_id=0, four consecutive fifo_wr_en pulses with data in order, each one cycle after acceptance; busy drops after beat 4.
- All 4 requesters valid continuously, each burst 2 beats → grant order 0,1,2,3,0, one bubble cycle between bursts.
- Requester 2 sends 20 beats without last, BURST_MAX=16 → 16 beats written, grant released, re-grant to 2 after the bubble (other requesters idle), remaining 4 beats written.
- fifo_prog_full=1 with requests pending → no grant, busy=0. Deassert → grant on the next edge.
- fifo_full pulsed for 3 cycles mid-burst → req_ready low for those 3 cycles, no fifo_wr_en, no data lost or duplicated.
- rst asserted during beat 3 of a burst → all outputs 0 and rr_ptr=0 immediately. After release, requester 0 wins first. With PICO_ARB_PARITY_EN, din byte 8'h07 → corresponding dinp bit =1.

Source files
------------

// File: rtl/pico_arb_pkg.sv
// Shared types, widths and the round-robin search used by the FIFO write arbiter.
package pico_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DATA_W  = 128;
    localparam int PAR_W   = 16;
    localparam int MAX_REQ = 8;

    // Returns the first set bit of req at or after ptr, wrapping at n.
    // The loop walks from the far end so the nearest hit is written last.
    function automatic int rr_search(input logic [MAX_REQ-1:0] req,
                                     input int ptr,
                                     input int n);
        int idx;
        int found;
        found = 0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[3'(idx)]) begin
                    found = idx;
                end
            end
        end
        return found;
    endfunction

endpackage

// File: rtl/pico_rr_pick.sv
// Combinational round-robin priority picker: lowest requester at or after ptr wins.
module pico_rr_pick
    import pico_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [IDW-1:0]     gnt_idx,
    output logic               any
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req;
        gnt_idx                = IDW'(rr_search(req_ext, int'(ptr), NUM_REQ));
        any                    = |req;
    end

endmodule

// File: rtl/pico_fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one 512x128 FIFO write port between NUM_REQ producers.
// Optional byte parity on fifo_dinp is enabled by defining PICO_ARB_PARITY_EN.
module pico_fifo_wr_arbiter
    import pico_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BURST_MAX = 16,
    parameter int IDW       = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]           fifo_din,
    output logic [PAR_W-1:0]            fifo_dinp,
    output logic                        fifo_wr_en,
    input  logic                        fifo_full,
    input  logic                        fifo_prog_full,
    output logic [IDW-1:0]              grant_id,
    output logic                        busy
);

    localparam int CNT_W = $clog2(BURST_MAX + 1);

    arb_state_e         state_q, state_d;
    logic [IDW-1:0]     grant_id_q, grant_id_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic               wr_en_q, wr_en_d;

    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [DATA_W-1:0]  sel_data;
    logic               sel_valid;
    logic               sel_last;
    logic [IDW-1:0]     next_ptr;

    pico_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == IDW'(i)) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        sel_valid = req_valid[grant_id_q];
        sel_last  = req_last[grant_id_q];
        next_ptr  = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
    end

    // fifo_full feeds req_ready combinationally; prog_full only gates new grants,
    // since BURST_MAX fits below the almost-full threshold.
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        din_d      = din_q;
        wr_en_d    = 1'b0;
        req_ready  = '0;

        case (state_q)
            IDLE: begin
                if (pick_any && !fifo_prog_full) begin
                    state_d    = BURST;
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                req_ready[grant_id_q] = !fifo_full;
                if (sel_valid && !fifo_full) begin
                    wr_en_d    = 1'b1;
                    din_d      = sel_data;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (sel_last || beat_cnt_q == CNT_W'(BURST_MAX - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            din_q      <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            din_q      <= din_d;
            wr_en_q    <= wr_en_d;
        end
    end

`ifdef PICO_ARB_PARITY_EN
    logic [PAR_W-1:0] dinp_q, dinp_d;

    // Even parity per byte, computed from the next data so it registers alongside it.
    always_comb begin
        dinp_d = '0;
        for (int k = 0; k < PAR_W; k++) begin
            dinp_d[k] = ^din_d[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dinp_q <= '0;
        end else begin
            dinp_q <= dinp_d;
        end
    end

    assign fifo_dinp = dinp_q;
`else
    assign fifo_dinp = '0;
`endif

    assign fifo_din   = din_q;
    assign fifo_wr_en = wr_en_q;
    assign grant_id   = grant_id_q;
    assign busy       = (state_q == BURST);

endmodule

// File: tb/tb_pico_fifo_wr_arbiter.sv
// Randomized bench for pico_fifo_wr_arbiter against a beat-level reference model.
module tb_pico_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int BURST_MAX = 16;
    localparam int IDW       = 2;
    localparam int NCYC      = 2400;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*128-1:0]    req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [127:0]              fifo_din;
    logic [15:0]               fifo_dinp;
    logic                      fifo_wr_en;
    logic                      fifo_full;
    logic                      fifo_prog_full;
    logic [IDW-1:0]            grant_id;
    logic                      busy;

    int total = 0;
    int bad   = 0;

    // producer state: each requester presents its next numbered beat until accepted
    logic [127:0] cur_data [NUM_REQ];
    int           seq      [NUM_REQ];

    // reference model of what the arbiter should present
    bit           m_busy;
    int           m_gid;
    int           m_ptr;
    int           m_beats;
    bit           m_wr;
    logic [127:0] m_din;
    int           m_writes;

    pico_fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_data       (req_data),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .fifo_din       (fifo_din),
        .fifo_dinp      (fifo_dinp),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_full      (fifo_full),
        .fifo_prog_full (fifo_prog_full),
        .grant_id       (grant_id),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%h want=%h", tag, $time, actual, expected);
        end
    endtask

    task automatic newBeat(input int i);
        seq[i]++;
        cur_data[i] = {8'(i), 24'(seq[i]), $urandom, $urandom, $urandom};
    endtask

    function automatic logic [15:0] expParity(input logic [127:0] d);
        logic [15:0] p;
        p = '0;
`ifdef PICO_ARB_PARITY_EN
        for (int k = 0; k < 16; k++) begin
            p[k] = ^d[8*k +: 8];
        end
`endif
        return p;
    endfunction

    task automatic modelReset();
        m_busy  = 1'b0;
        m_gid   = 0;
        m_ptr   = 0;
        m_beats = 0;
        m_wr    = 1'b0;
        m_din   = '0;
    endtask

    // Phase selects the traffic mix: mixed, long no-last bursts, blocked by prog_full, saturated.
    task automatic applyStimulus(input int cyc);
        int pv, pl, pf, pp;
        if (cyc < 800) begin
            pv = 75; pl = 30; pf = 15; pp = 20;
        end else if (cyc < 1400) begin
            pv = 90; pl = 0;  pf = 5;  pp = 10;
        end else if (cyc < 1450) begin
            pv = 100; pl = 30; pf = 0; pp = 100;
        end else begin
            pv = 100; pl = 50; pf = 0; pp = 0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]               = ($urandom_range(99) < pv);
            req_last[i]                = ($urandom_range(99) < pl);
            req_data[i*128 +: 128]     = cur_data[i];
        end
        fifo_full      = ($urandom_range(99) < pf);
        fifo_prog_full = ($urandom_range(99) < pp);
    endtask

    // One clock edge of arbiter behaviour, stated at the beat/burst level.
    task automatic modelStep();
        bit found;
        int cand;
        m_wr = 1'b0;
        if (!m_busy) begin
            if (req_valid != '0 && !fifo_prog_full) begin
                found = 1'b0;
                for (int off = 0; off < NUM_REQ; off++) begin
                    cand = (m_ptr + off) % NUM_REQ;
                    if (!found && req_valid[cand]) begin
                        found = 1'b1;
                        m_gid = cand;
                    end
                end
                m_busy  = 1'b1;
                m_beats = 0;
            end
        end else if (req_valid[m_gid] && !fifo_full) begin
            m_wr  = 1'b1;
            m_din = cur_data[m_gid];
            m_beats++;
            m_writes++;
            if (req_last[m_gid] || m_beats == BURST_MAX) begin
                m_busy = 1'b0;
                m_ptr  = (m_gid + 1) % NUM_REQ;
            end
            newBeat(m_gid);
        end
    endtask

    task automatic checkAll();
        logic [NUM_REQ-1:0] exp_ready;
        exp_ready = '0;
        if (m_busy && !fifo_full) begin
            exp_ready[m_gid] = 1'b1;
        end
        checkOutput("req_ready", 128'(req_ready), 128'(exp_ready));
        checkOutput("busy", 128'(busy), 128'(m_busy));
        checkOutput("grant_id", 128'(grant_id), 128'(m_gid));
        checkOutput("wr_en", 128'(fifo_wr_en), 128'(m_wr));
        checkOutput("din", fifo_din, m_din);
        checkOutput("dinp", 128'(fifo_dinp), 128'(expParity(m_din)));
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = '0;
        req_last       = '0;
        req_data       = '0;
        fifo_full      = 1'b0;
        fifo_prog_full = 1'b0;
        m_writes       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            seq[i] = 0;
            newBeat(i);
        end
        modelReset();

        @(negedge clk);
        #1;
        checkAll();
        @(negedge clk);
        rst = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc != 0) begin
                @(negedge clk);
            end
            if (rst) begin
                rst = 1'b0;
            end
            applyStimulus(cyc);
            #1;
            checkAll();
            if (cyc == 600 || cyc == 1700) begin
                rst = 1'b1;
                modelReset();
                #1;
                checkAll();
            end
            @(posedge clk);
            if (!rst) begin
                modelStep();
            end
        end

        @(negedge clk);
        #1;
        checkAll();
        $display("[TB] beats written by model: %0d", m_writes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
